// File: rtl/tx.sv
// Baseband transmitter: maps one bit per symbol to +/-1 and shapes it with a polyphase
// upsampling FIR. Optional internal PRBS9 bit source enabled by defining TX_PRBS_EN.
module tx #(
    parameter int UPSAMPLE   = 4,
    parameter int NCOEF      = 24,
    parameter int COEF_NBITS = 8,
    parameter int COEF_FBITS = 7,
    parameter int DATA_NBITS = 8,
    parameter logic [NCOEF*COEF_NBITS-1:0] COEF = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         tx_in,
`ifdef TX_PRBS_EN
    input  logic                         prbs_sel,
`endif
    output logic                         tx_load,
    output logic signed [DATA_NBITS-1:0] tx_out
);

    localparam int NBAUD = NCOEF / UPSAMPLE;
    localparam int PW    = $clog2(UPSAMPLE);
    localparam int SW    = COEF_NBITS + $clog2(NBAUD) + 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(UPSAMPLE - 1);

    generate
        if (UPSAMPLE < 2 || (UPSAMPLE & (UPSAMPLE - 1)) != 0) begin : g_bad_upsample
            $error("UPSAMPLE must be a power of two and at least 2");
        end
        if (NCOEF % UPSAMPLE != 0 || NBAUD < 2) begin : g_bad_ncoef
            $error("NCOEF must be a multiple of UPSAMPLE spanning at least two symbols");
        end
        if (COEF_FBITS >= COEF_NBITS) begin : g_bad_fbits
            $error("COEF_FBITS must leave a sign bit in COEF_NBITS");
        end
    endgenerate

    logic [PW-1:0]                 phase_q, phase_d;
    logic [NBAUD-1:0]              bits_q, bits_d;
    logic [NBAUD-1:0]              vld_q, vld_d;
    logic signed [DATA_NBITS-1:0]  tx_out_q, tx_out_d;
    logic signed [SW-1:0]          sum_d;
    logic                          load_edge;
    logic                          load_bit;

    // bank[k][p] holds coef[k*UPSAMPLE + p]; coef[0] sits in the MSBs of COEF.
    logic signed [COEF_NBITS-1:0]  bank [NBAUD][UPSAMPLE];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NBAUD; gi++) begin : g_baud
            for (gj = 0; gj < UPSAMPLE; gj++) begin : g_phase
                assign bank[gi][gj] =
                    COEF[(NCOEF - 1 - (gi*UPSAMPLE + gj))*COEF_NBITS +: COEF_NBITS];
            end
        end
    endgenerate

    assign load_edge = enable && (phase_q == LAST_PHASE);
    assign tx_load   = rst && load_edge;

`ifdef TX_PRBS_EN
    logic [8:0] prbs_q, prbs_d;

    assign load_bit = prbs_sel ? prbs_q[8] : tx_in;

    always_comb begin
        prbs_d = prbs_q;
        if (load_edge) begin
            prbs_d = {prbs_q[7:0], prbs_q[8] ^ prbs_q[4]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prbs_q <= 9'h1FF;
        end else begin
            prbs_q <= prbs_d;
        end
    end
`else
    assign load_bit = tx_in;
`endif

    // Symbols outside the valid window contribute nothing, so start-up has no -1 history.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NBAUD; k++) begin
            if (vld_q[k]) begin
                if (bits_q[k]) begin
                    sum_d = sum_d + SW'(bank[k][phase_q]);
                end else begin
                    sum_d = sum_d - SW'(bank[k][phase_q]);
                end
            end
        end
    end

    generate
        if (SW > DATA_NBITS) begin : g_sat
            localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_NBITS - 1)) - 1);
            localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DATA_NBITS - 1)));
            always_comb begin
                if (sum_d > SAT_MAX) begin
                    tx_out_d = {1'b0, {(DATA_NBITS-1){1'b1}}};
                end else if (sum_d < SAT_MIN) begin
                    tx_out_d = {1'b1, {(DATA_NBITS-1){1'b0}}};
                end else begin
                    tx_out_d = sum_d[DATA_NBITS-1:0];
                end
            end
        end else begin : g_nosat
            assign tx_out_d = DATA_NBITS'(sum_d);
        end
    endgenerate

    always_comb begin
        phase_d = phase_q;
        bits_d  = bits_q;
        vld_d   = vld_q;
        if (enable) begin
            phase_d = phase_q + PW'(1);
            if (phase_q == LAST_PHASE) begin
                bits_d = {bits_q[NBAUD-2:0], load_bit};
                vld_d  = {vld_q[NBAUD-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= '0;
            bits_q   <= '0;
            vld_q    <= '0;
            tx_out_q <= '0;
        end else begin
            phase_q <= phase_d;
            bits_q  <= bits_d;
            vld_q   <= vld_d;
            if (enable) begin
                tx_out_q <= tx_out_d;
            end
        end
    end

    assign tx_out = tx_out_q;

endmodule

// File: tb/tb_tx.sv
// Scoreboard bench for tx: three instances (flat 8, flat 127, ramp 1..24 taps) share one
// stimulus stream; a behavioural model pushes expected samples that are popped after each edge.
module tb_tx;

    localparam int NB = 6;
    localparam logic [191:0] COEF_A = {24{8'h08}};
    localparam logic [191:0] COEF_B = {24{8'h7F}};

    function automatic logic [191:0] ramp_coef();
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 24; i++) r[(23-i)*8 +: 8] = 8'(i + 1);
        return r;
    endfunction
    localparam logic [191:0] COEF_C = ramp_coef();

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic tx_in = 1'b0;
`ifdef TX_PRBS_EN
    logic prbs_sel = 1'b0;
`endif
    logic load_a, load_b, load_c;
    logic signed [7:0] out_a, out_b, out_c;

    always #5 clk = ~clk;

    tx #(.UPSAMPLE(4), .NCOEF(24), .COEF_NBITS(8), .COEF_FBITS(7), .DATA_NBITS(8), .COEF(COEF_A))
    u_dut_a (.clk(clk), .rst(rst), .enable(enable), .tx_in(tx_in),
`ifdef TX_PRBS_EN
             .prbs_sel(prbs_sel),
`endif
             .tx_load(load_a), .tx_out(out_a));

    tx #(.UPSAMPLE(4), .NCOEF(24), .COEF_NBITS(8), .COEF_FBITS(7), .DATA_NBITS(8), .COEF(COEF_B))
    u_dut_b (.clk(clk), .rst(rst), .enable(enable), .tx_in(tx_in),
`ifdef TX_PRBS_EN
             .prbs_sel(prbs_sel),
`endif
             .tx_load(load_b), .tx_out(out_b));

    tx #(.UPSAMPLE(4), .NCOEF(24), .COEF_NBITS(8), .COEF_FBITS(7), .DATA_NBITS(8), .COEF(COEF_C))
    u_dut_c (.clk(clk), .rst(rst), .enable(enable), .tx_in(tx_in),
`ifdef TX_PRBS_EN
             .prbs_sel(prbs_sel),
`endif
             .tx_load(load_c), .tx_out(out_c));

    int n_checks = 0;
    int n_fail   = 0;

    int  coefs [3][24];
    int  m_phase;
    bit  m_bits [NB];
    bit  m_vld  [NB];
    int  m_out  [3];
    bit [8:0] m_prbs;
    int  exp_q [$];
    int  last_load;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int s);
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    function automatic int model_sum(input int d);
        int s;
        s = 0;
        for (int k = 0; k < NB; k++) begin
            if (m_vld[k]) s += (m_bits[k] ? 1 : -1) * coefs[d][k*4 + m_phase];
        end
        return s;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        for (int k = 0; k < NB; k++) begin
            m_bits[k] = 1'b0;
            m_vld[k]  = 1'b0;
        end
        for (int d = 0; d < 3; d++) m_out[d] = 0;
        m_prbs = 9'h1FF;
    endtask

    // Drive one clock of stimulus, check tx_load before the edge and outputs after it.
    task automatic cycle(input bit en, input bit din);
        int exp_load;
        bit nb;
        enable = en;
        tx_in  = din;
        #1;
        exp_load  = (en && m_phase == 3) ? 1 : 0;
        last_load = int'(load_a);
        check_eq("tx_load_a", int'(load_a), exp_load);
        check_eq("tx_load_c", int'(load_c), exp_load);
        if (en) begin
            for (int d = 0; d < 3; d++) m_out[d] = sat8(model_sum(d));
            if (m_phase == 3) begin
                nb = din;
`ifdef TX_PRBS_EN
                if (prbs_sel) nb = m_prbs[8];
                m_prbs = {m_prbs[7:0], m_prbs[8] ^ m_prbs[4]};
`endif
                for (int k = NB - 1; k > 0; k--) begin
                    m_bits[k] = m_bits[k-1];
                    m_vld[k]  = m_vld[k-1];
                end
                m_bits[0] = nb;
                m_vld[0]  = 1'b1;
            end
            m_phase = (m_phase + 1) % 4;
        end
        for (int d = 0; d < 3; d++) exp_q.push_back(m_out[d]);
        @(posedge clk);
        #1;
        check_eq("tx_out_a", int'(out_a), exp_q.pop_front());
        check_eq("tx_out_b", int'(out_b), exp_q.pop_front());
        check_eq("tx_out_c", int'(out_c), exp_q.pop_front());
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_out_a", int'(out_a), 0);
        check_eq("async_rst_out_c", int'(out_c), 0);
        check_eq("async_rst_load", int'(load_a), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 24; i++) begin
            coefs[0][i] = 8;
            coefs[1][i] = 127;
            coefs[2][i] = i + 1;
        end
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_out_a", int'(out_a), 0);
        check_eq("reset_out_b", int'(out_b), 0);
        enable = 1'b1;
        #1;
        check_eq("reset_load_en", int'(load_a), 0);
        rst = 1'b1;

        // Settling to +48 / saturation at +127 with ones held.
        repeat (44) cycle(1'b1, 1'b1);
        check_eq("settle_pos_a", int'(out_a), 48);
        check_eq("sat_pos_b", int'(out_b), 127);

        // Swing to the negative rail with zeros held.
        repeat (28) cycle(1'b1, 1'b0);
        check_eq("settle_neg_a", int'(out_a), -48);
        check_eq("sat_neg_b", int'(out_b), -128);

        // Reset mid-symbol, then impulse response on the ramp instance.
        cycle(1'b1, 1'b0);
        async_reset();
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check_eq("first_load_after_rst", last_load, 1);
        for (int p = 0; p < 4; p++) begin
            cycle(1'b1, 1'b1);
            check_eq("impulse_first", int'(out_c), p + 1);
        end
        for (int p = 0; p < 4; p++) begin
            cycle(1'b1, 1'b1);
            check_eq("impulse_second", int'(out_c), 6 + 2*p);
        end

        // Random data with an enable gap landing mid-symbol.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
        repeat (5) cycle(1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'($urandom_range(0, 1)));

`ifdef TX_PRBS_EN
        async_reset();
        prbs_sel = 1'b1;
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'(i));
        prbs_sel = 1'b0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
